shiftin: RTL
============

// Module: shiftin
// PURPOSE
//   Serial-to-parallel receiver for the latch/clock/data 3-wire shift bus.
//   Frame = SHIFT_LATCH low, DATA_WIDTH rising edges of SHIFT_CLOCK, SHIFT_LATCH high.
//   Bits arrive LSB first. Data is stable at each SHIFT_CLOCK rise.
//   Inputs are asynchronous to CLK. The block synchronises them, deserialises the frame,
//   and presents one parallel word with a single-cycle valid strobe.
//   Used for board-to-board links and for loopback checking of the shift transmitter.
// PARAMETERS
//   DATA_WIDTH   32                      bits per frame
//   FREQUENCY    1_000                   nominal shift bit rate (Hz)
//   CLKS_PER_BIT 12_000_000/FREQUENCY    CLK cycles per bit period
//   TIMEOUT_CLKS 4*CLKS_PER_BIT          idle-clock limit inside a frame (SHIFTIN_TIMEOUT_EN only)
// PORTS
//   CLK          in   1           system clock, 12 MHz
//   RST_N        in   1           synchronous active-low reset
//   SHIFT_LATCH  in   1           async; idle high, low for the frame
//   SHIFT_CLOCK  in   1           async; sample SHIFT_DATA on rise
//   SHIFT_DATA   in   1           async serial data
//   OUT_DATA     out  DATA_WIDTH  last good received word
//   OUT_VALID    out  1           1-cycle pulse: OUT_DATA just updated
//   FRAME_ERROR  out  1           1-cycle pulse: frame discarded
//   BUSY         out  1           high while a frame is in progress
// BEHAVIOUR
//   - Reset (RST_N=0 at a CLK edge): OUT_DATA=0, OUT_VALID=0, FRAME_ERROR=0, BUSY=0, state=IDLE.
//     Bit count and shift register are cleared.
//     Synchroniser flops reset to idle levels: latch=1, clock=0, data=0.
//   - Each input passes through a 2-flop synchroniser plus 1 history flop.
//     Edges are detected on synced value vs. history.
//   - Latency: an edge first sampled at CLK edge k takes effect at edge k+2.
//     OUT_VALID and FRAME_ERROR are high for the cycle after edge k+2.
//   - IDLE: BUSY=0.
//     Latch falling edge -> RECEIVE; clear bit count and shift register.
//     Clock and latch-rise events in IDLE are ignored.
//   - RECEIVE: BUSY=1.
//     On each clock rising edge: shreg <= {data_sync, shreg[W-1:1]}; count++.
//     The count saturates at DATA_WIDTH+1.
//   - RECEIVE, latch rising edge: if count==DATA_WIDTH, OUT_DATA<=shreg and pulse OUT_VALID.
//     Otherwise (short or long frame) pulse FRAME_ERROR and leave OUT_DATA unchanged.
//     Either way -> IDLE.
//   - Clock rise and latch rise detected in the same cycle: shift the bit in first, then
//     evaluate the count including that bit.
//   - OUT_VALID and FRAME_ERROR are never high in the same cycle.
//   - Back-to-back frames: a latch fall in the cycle after the IDLE return is accepted.
//     Minimum inter-frame gap is 1 synced cycle.
//   - Reset mid-frame: the frame is abandoned.
//     If the latch is still low after release, a falling edge is seen (history flop = 1).
//     The remainder is then received and ends in FRAME_ERROR (short count).
//   - No backpressure: OUT_DATA holds until the next good frame.
// CONFIGURATION
//   SHIFTIN_TIMEOUT_EN defined:
//     - RECEIVE runs a counter, cleared on entry and on every clock rising edge.
//     - When the counter reaches TIMEOUT_CLKS-1: pulse FRAME_ERROR, go to IDLE.
//     - The later latch rise is ignored; no second pulse.
//   SHIFTIN_TIMEOUT_EN undefined:
//     - No counter, and TIMEOUT_CLKS is unused.
//     - RECEIVE exits only on a latch rise or reset.
// TESTING  (DATA_WIDTH=8, FREQUENCY=1_000_000 -> CLKS_PER_BIT=12; bench drives transmitter timing)
//   1. Frame 0xA5 LSB first, 8 clocks -> OUT_DATA=0xA5, one OUT_VALID pulse 2 edges after latch rise, FRAME_ERROR=0.
//   2. After 1, 7-clock frame -> one FRAME_ERROR pulse, no OUT_VALID, OUT_DATA stays 0xA5.
//   3. 9-clock frame of 0x3C+extra bit -> FRAME_ERROR pulse, OUT_DATA unchanged.
//   4. Back-to-back 0x01 then 0x80 with a 1-bit-period gap -> two OUT_VALID pulses, values 0x01 then 0x80.
//   5. RST_N low 3 cycles after bit 4 of 0xFF, remaining 4 bits, latch rise -> outputs 0 during reset, then FRAME_ERROR, OUT_DATA=0.
//   6. With macro: latch low, 3 clocks, stall 60 cycles -> FRAME_ERROR at cycle TIMEOUT_CLKS=48, BUSY=0, no pulse at later latch rise.
//      Without macro: no pulse until latch rise, then FRAME_ERROR.

Source files
------------

// File: rtl/shiftin.sv
// shiftin: latch/clock/data shift-bus receiver, LSB first, one parallel word per frame.
// Define SHIFTIN_TIMEOUT_EN to abandon frames whose shift clock stalls for TIMEOUT_CLKS cycles.
module shiftin #(
    parameter int DATA_WIDTH   = 32,
    parameter int FREQUENCY    = 1_000,
    parameter int CLKS_PER_BIT = 12_000_000 / FREQUENCY,
    parameter int TIMEOUT_CLKS = 4 * CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_latch,
    input  logic                  shift_clock,
    input  logic                  shift_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  frame_error,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 2);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t                state;
    logic [2:0]            latch_q, clock_q;
    logic [1:0]            data_q;
    logic [CW-1:0]         count, count_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic                  latch_fall, latch_rise, clock_rise;
    // bit [1] is the synchronised level, bit [2] the history used for edge detection
    assign latch_fall = latch_q[2] & ~latch_q[1];
    assign latch_rise = ~latch_q[2] & latch_q[1];
    assign clock_rise = ~clock_q[2] & clock_q[1];
    assign shreg_nx   = clock_rise ? {data_q[1], shreg[DATA_WIDTH-1:1]} : shreg;
    assign count_nx   = (clock_rise && count != CW'(DATA_WIDTH + 1)) ? count + CW'(1) : count;
`ifdef SHIFTIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    logic [TW-1:0] tcnt;
    logic          timeout;
    assign timeout = !clock_rise && tcnt == TW'(TIMEOUT_CLKS - 1);
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_q     <= 3'b111;
            clock_q     <= '0;
            data_q      <= '0;
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
`ifdef SHIFTIN_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            latch_q     <= {latch_q[1:0], shift_latch};
            clock_q     <= {clock_q[1:0], shift_clock};
            data_q      <= {data_q[0], shift_data};
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE) begin
                if (latch_fall) begin
                    state <= RECEIVE;
                    busy  <= 1'b1;
                    count <= '0;
                    shreg <= '0;
`ifdef SHIFTIN_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
            end else begin
                count <= count_nx;
                shreg <= shreg_nx;
`ifdef SHIFTIN_TIMEOUT_EN
                tcnt  <= clock_rise ? '0 : tcnt + TW'(1);
`endif
                // a bit arriving with the latch rise is counted before the length check
                if (latch_rise) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (count_nx == CW'(DATA_WIDTH)) begin
                        out_data  <= shreg_nx;
                        out_valid <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
`ifdef SHIFTIN_TIMEOUT_EN
                else if (timeout) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    frame_error <= 1'b1;
                end
`else
`endif
            end
        end
    end
endmodule
